// File: rtl/act_pkg.sv
// act_pkg: activation mode codes and the rounded 1/6 fixed-point constant
package act_pkg;
    localparam logic [2:0] ACT_ID     = 3'd0;
    localparam logic [2:0] ACT_RELU   = 3'd1;
    localparam logic [2:0] ACT_RELU6  = 3'd2;
    localparam logic [2:0] ACT_HSIG   = 3'd3;
    localparam logic [2:0] ACT_HSWISH = 3'd4;
    function automatic int recip(input int rb);
        return ((1 << rb) + 3) / 6;
    endfunction
endpackage

// File: rtl/act_if.sv
// act_if: beat-level valid/ready bus between the requant stage, act_unit and the writer
interface act_if #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 26,
    parameter int OUT_WIDTH  = 14
);
    logic                          en;
    logic                          in_ready;
    logic [2:0]                    mode;
    logic [LANES*DATA_WIDTH-1:0]   input_data;
    logic                          clear;
    logic [LANES*OUT_WIDTH-1:0]    output_data;
    logic                          valid;
    logic                          out_ready;
    modport master (output en, mode, input_data, clear, out_ready, input in_ready, output_data, valid);
    modport slave  (input en, mode, input_data, clear, out_ready, output in_ready, output_data, valid);
endinterface

// File: rtl/act_lane.sv
// act_lane: one lane of the activation datapath, four register stages advancing together
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 26,
    parameter int FRAC_BITS  = 7,
    parameter int OUT_WIDTH  = 14,
    parameter int RECIP_BITS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_adv,
    input  logic [2:0]                   i_mode,
    input  logic signed [DATA_WIDTH-1:0] i_x,
    output logic signed [OUT_WIDTH-1:0]  o_y
);
    localparam int XW = DATA_WIDTH + 1;
    localparam int TW = FRAC_BITS + 4;
    localparam int PW = DATA_WIDTH + FRAC_BITS + 5;
    localparam int MW = PW + RECIP_BITS - 1;
    localparam logic signed [XW-1:0] THREE  = XW'(3 << FRAC_BITS);
    localparam logic signed [XW-1:0] SIX    = XW'(6 << FRAC_BITS);
    localparam logic signed [MW-1:0] RECIP  = MW'(recip(RECIP_BITS));
    localparam logic signed [MW-1:0] HALF_R = MW'(1) <<< (RECIP_BITS - 1);
    localparam logic signed [PW-1:0] HALF_F = PW'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [PW-1:0] OMAX   = PW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] OMIN   = -OMAX - PW'(1);
    localparam logic signed [PW-1:0] SIXP   = PW'(SIX);
    logic signed [XW-1:0]         w_sum;
    logic signed [TW-1:0]         w_t;
    logic signed [PW-1:0]         w_p, w_sw, w_xe, w_r;
    logic signed [MW-1:0]         w_m, w_h;
    logic signed [DATA_WIDTH-1:0] r1_x, r2_x, r3_x;
    logic signed [TW-1:0]         r1_t, r2_t, r3_h;
    logic signed [PW-1:0]         r2_p, r3_q;
    assign w_sum = XW'(i_x) + THREE;
    assign w_t   = w_sum[XW-1] ? '0 : (w_sum > SIX ? TW'(SIX) : TW'(w_sum));
    assign w_p   = PW'(r1_x) * PW'(r1_t);
    assign w_m   = MW'(r2_p) * RECIP;
    assign w_h   = MW'(r2_t) * RECIP + HALF_R;
    assign w_sw  = (r3_q + HALF_F) >>> FRAC_BITS;
    assign w_xe  = PW'(r3_x);
    // Out-of-range modes fall through to identity
    always_comb begin
        w_r = i_mode == ACT_RELU   ? (w_xe[PW-1] ? '0 : w_xe) :
              i_mode == ACT_RELU6  ? (w_xe[PW-1] ? '0 : (w_xe > SIXP ? SIXP : w_xe)) :
              i_mode == ACT_HSIG   ? PW'(r3_h) :
              i_mode == ACT_HSWISH ? w_sw : w_xe;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_x <= '0;
            r1_t <= '0;
            r2_x <= '0;
            r2_t <= '0;
            r2_p <= '0;
            r3_x <= '0;
            r3_h <= '0;
            r3_q <= '0;
            o_y  <= '0;
        end else if (i_adv) begin
            r1_x <= i_x;
            r1_t <= w_t;
            r2_x <= r1_x;
            r2_t <= r1_t;
            r2_p <= w_p;
            r3_x <= r2_x;
            r3_h <= TW'(w_h >>> RECIP_BITS);
            r3_q <= PW'(w_m >>> RECIP_BITS);
            o_y  <= w_r > OMAX ? OUT_WIDTH'(OMAX) : (w_r < OMIN ? OUT_WIDTH'(OMIN) : OUT_WIDTH'(w_r));
        end
    end
endmodule

// File: rtl/act_unit.sv
// act_unit: multi-lane activation pipeline with a global stall and synchronous flush
module act_unit
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 26,
    parameter int FRAC_BITS  = 7,
    parameter int OUT_WIDTH  = 14,
    parameter int LANES      = 4,
    parameter int RECIP_BITS = 16
) (
    input logic  clk,
    input logic  rst_n,
    act_if.slave bus
);
    logic                       w_adv;
    logic [3:0]                 r_v;
    logic [2:0]                 r_m1, r_m2, r_m3;
    logic [LANES*OUT_WIDTH-1:0] w_out;
    assign w_adv           = ~r_v[3] | bus.out_ready;
    assign bus.in_ready    = w_adv;
    assign bus.valid       = r_v[3];
    assign bus.output_data = w_out;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v  <= '0;
            r_m1 <= ACT_ID;
            r_m2 <= ACT_ID;
            r_m3 <= ACT_ID;
        end else if (bus.clear) begin
            r_v <= '0;
        end else if (w_adv) begin
            r_v  <= {r_v[2:0], bus.en};
            r_m1 <= bus.mode;
            r_m2 <= r_m1;
            r_m3 <= r_m2;
        end
    end
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        act_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .FRAC_BITS (FRAC_BITS),
            .OUT_WIDTH (OUT_WIDTH),
            .RECIP_BITS(RECIP_BITS)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .i_adv (w_adv),
            .i_mode(r_m3),
            .i_x   (bus.input_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .o_y   (w_out[i*OUT_WIDTH +: OUT_WIDTH])
        );
    end
endmodule

// File: tb/tb_act_unit.sv
// tb_act_unit: directed vectors, backpressure stream, clear and reset checks for act_unit
module tb_act_unit;
    typedef logic [3:0][31:0] vec4_t;
    typedef struct packed {
        logic [2:0] m;
        vec4_t      x;
        vec4_t      y;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[12];
    logic [55:0] q[$];

    always #5 clk = ~clk;

    act_if #(.LANES(4), .DATA_WIDTH(26), .OUT_WIDTH(14)) bus();
    act_if #(.LANES(1), .DATA_WIDTH(16), .OUT_WIDTH(8))  sb();

    act_unit #(.DATA_WIDTH(26), .FRAC_BITS(7), .OUT_WIDTH(14), .LANES(4), .RECIP_BITS(16))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    act_unit #(.DATA_WIDTH(16), .FRAC_BITS(7), .OUT_WIDTH(8), .LANES(1), .RECIP_BITS(16))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(sb));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] m, input int x0, x1, x2, x3, y0, y1, y2, y3);
        vec_t v;
        v.m = m;
        v.x = {x3, x2, x1, x0};
        v.y = {y3, y2, y1, y0};
        return v;
    endfunction

    function automatic longint lane(input int i);
        return longint'($signed(bus.output_data[i*14 +: 14]));
    endfunction

    function automatic longint model1(input logic [2:0] m, input longint x);
        longint t, r;
        t = x + 384;
        if (t < 0) t = 0;
        if (t > 768) t = 768;
        case (m)
            3'd1:    r = (x < 0) ? 0 : x;
            3'd2:    r = (x < 0) ? 0 : ((x > 768) ? 768 : x);
            3'd3:    r = (t * 10923 + 32768) >>> 16;
            3'd4:    r = ((((x * t) * 10923) >>> 16) + 64) >>> 7;
            default: r = x;
        endcase
        if (r > 8191) r = 8191;
        if (r < -8192) r = -8192;
        return r;
    endfunction

    function automatic logic [55:0] model4(input logic [2:0] m, input vec4_t x);
        logic [55:0] r;
        for (int i = 0; i < 4; i++) r[i*14 +: 14] = 14'(model1(m, longint'($signed(x[i]))));
        return r;
    endfunction

    task automatic drive(input logic [2:0] m, input vec4_t x);
        bus.mode = m;
        for (int i = 0; i < 4; i++) bus.input_data[i*26 +: 26] = x[i][25:0];
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        bus.en = 1'b1;
        drive(v.m, v.x);
        @(negedge clk);
        bus.en = 1'b0;
        lat = 1;
        while (!bus.valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_lane%0d", tag, i), lane(i), longint'($signed(v.y[i])));
    endtask

    initial begin
        int lat, sent, got, vh;
        logic stall;
        logic [55:0] held, e;
        vec4_t rx;
        logic [2:0] rm;

        tbl[0]  = mk(3'd4, 256, 1024, -512, 0,        213, 1024, 0, 0);
        tbl[1]  = mk(3'd4, -128, 2000, -384, 384,     -43, 2000, 0, 384);
        tbl[2]  = mk(3'd3, 0, -384, 384, 1000,        64, 0, 128, 128);
        tbl[3]  = mk(3'd2, 1000, -50, 500, 768,       768, 0, 500, 768);
        tbl[4]  = mk(3'd1, -5, 9000, 77, 0,           0, 8191, 77, 0);
        tbl[5]  = mk(3'd0, 20000, -20000, 8192, -8193, 8191, -8192, 8191, -8192);
        tbl[6]  = mk(3'd5, 100, -100, 8191, -8192,    100, -100, 8191, -8192);
        tbl[7]  = mk(3'd7, 20000, -1, 0, 5,           8191, -1, 0, 5);
        tbl[8]  = mk(3'd3, -1000, 192, -192, 0,       0, 96, 32, 64);
        tbl[9]  = mk(3'd6, -20000, 1, -1, 8191,       -8192, 1, -1, 8191);
        tbl[10] = mk(3'd4, 33554431, -33554432, 1, -1, 8191, 0, 1, 0);
        tbl[11] = mk(3'd2, 33554431, -33554432, 767, 769, 768, 0, 767, 768);

        bus.en = 1'b0; bus.clear = 1'b0; bus.mode = '0; bus.input_data = '0; bus.out_ready = 1'b1;
        sb.en = 1'b0;  sb.clear = 1'b0;  sb.mode = '0;  sb.input_data = '0;  sb.out_ready = 1'b1;

        #12;
        chk("rst_valid", bus.valid, 0);
        chk("rst_data", longint'(bus.output_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        for (int k = 0; k < 12; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

        @(negedge clk);
        sb.en = 1'b1; sb.mode = 3'd4; sb.input_data = 16'd256;
        @(negedge clk);
        sb.en = 1'b0;
        lat = 1;
        while (!sb.valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("narrow_latency", lat, 4);
        chk("narrow_hswish_sat", longint'($signed(sb.output_data)), 127);

        sent = 0; got = 0; stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
            @(negedge clk);
            if (stall) begin
                chk("hold_valid", bus.valid, 1);
                chk("hold_data", longint'(bus.output_data), longint'(held));
            end
            bus.out_ready = 1'($urandom_range(1));
            bus.en = (sent < 10);
            rm = 3'($urandom_range(7));
            for (int i = 0; i < 4; i++) rx[i] = 32'(int'($urandom_range(20000)) - 10000);
            drive(rm, rx);
            #1;
            if (bus.valid && bus.out_ready) begin
                if (q.size() == 0) chk("bp_extra_beat", got, -1);
                else begin
                    e = q.pop_front();
                    chk($sformatf("bp_beat%0d", got), longint'(bus.output_data), longint'(e));
                end
                got++;
            end
            if (bus.en && bus.in_ready) begin
                q.push_back(model4(rm, rx));
                sent++;
            end
            stall = bus.valid && !bus.out_ready;
            held = bus.output_data;
        end
        bus.en = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_received", got, 10);
        chk("bp_sent", sent, 10);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.en = 1'b1;
            drive(tbl[k].m, tbl[k].x);
        end
        @(negedge clk);
        bus.clear = 1'b1;
        drive(tbl[3].m, tbl[3].x);
        @(negedge clk);
        bus.clear = 1'b0;
        bus.en = 1'b0;
        vh = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.valid) vh++;
            @(negedge clk);
        end
        chk("clear_no_valid", vh, 0);
        run_vec(tbl[0], "post_clear");

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.en = 1'b1;
            drive(3'd0, {32'd7, 32'd5, 32'd3, 32'd256});
        end
        @(negedge clk);
        chk("pre_rst_valid", bus.valid, 1);
        chk("pre_rst_lane0", lane(0), 256);
        rst_n = 1'b0;
        bus.en = 1'b0;
        #1;
        chk("midrst_valid", bus.valid, 0);
        chk("midrst_data", longint'(bus.output_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        vh = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.valid) vh++;
        end
        chk("post_rst_no_valid", vh, 0);
        run_vec(tbl[1], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
